mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline: the EX/MEM pipeline register, the word-organised data memory with byte/halfword store enables, and load-data extension. It sits between the execute stage and the MEM/WB register. It produces `M_I`, `M_PC`, `M_AO` and the extended load word `M_RD` that MEM/WB latches. After every reset a built-in sweep FSM clears the data memory, and `busy` stalls the front of the pipe until the sweep completes.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/load_ext.sv | 33 +++
 rtl/mem_stage.sv | 145 ++++++++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the MIPS memory stage.
//   - Load/store opcode constants (instruction bits [31:26]).
//   - Sweep FSM state encoding.
//   - is_store(): true for the three store opcodes.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/load_ext.sv
// load_ext: lane select and sign/zero extension of a loaded word.
//   word    in  32  memory word (0 when the address is out of range)
//   addr_lo in  2   byte offset within the word
//   op      in  6   opcode; non-load opcodes give 0
//   result  out 32  extended load data
module load_ext
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [5:0]  op,
    output logic [31:0] result
);

    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        // Halfword selection ignores addr_lo[0]; misalignment is not trapped.
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        byte_v = word[8*addr_lo +: 8];
        result = '0;
        case (op)
            OP_LW:   result = word;
            OP_LH:   result = {{16{half_v[15]}}, half_v};
            OP_LHU:  result = {16'h0, half_v};
            OP_LB:   result = {{24{byte_v[7]}}, byte_v};
            OP_LBU:  result = {24'h0, byte_v};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM pipeline register, byte-enabled data memory and load
// extension. After each reset a sweep clears every memory word; busy stays
// high (and the EX/MEM register stays at its reset value) until it finishes.
//   clk, reset          clock, async active-low reset
//   en                  EX/MEM load enable (ignored while busy)
//   E_I/E_PC/E_AO/E_RT  instruction, PC, address, store data from EX
//   fwd_sel, W_WD       take store data from write-back instead of M_RT
//   M_I/M_PC/M_AO       registered EX/MEM contents
//   M_RD                extended load data (combinational)
//   busy                clear sweep in progress
module mem_stage
    import mips_pkg::*;
#(
    parameter int DM_WORDS = 3072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] E_I,
    input  logic [31:0] E_PC,
    input  logic [31:0] E_AO,
    input  logic [31:0] E_RT,
    input  logic        fwd_sel,
    input  logic [31:0] W_WD,
    output logic [31:0] M_I,
    output logic [31:0] M_PC,
    output logic [31:0] M_AO,
    output logic [31:0] M_RD,
    output logic        busy
);

    localparam int          AW       = (DM_WORDS > 1) ? $clog2(DM_WORDS) : 1;
    localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);
    localparam logic [AW-1:0] LAST   = AW'(DM_WORDS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [31:0]   m_i_q, m_i_d, m_pc_q, m_pc_d, m_ao_q, m_ao_d, m_rt_q, m_rt_d;

    logic [31:0]   mem_q [DM_WORDS];

    logic [5:0]    op;
    logic          in_range;
    logic [31:0]   sd;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;
    logic [AW-1:0] wr_idx;
    logic [31:0]   rd_word;

    assign busy     = (state_q == ST_INIT);
    assign op       = m_i_q[31:26];
    assign in_range = (m_ao_q < DM_BYTES);
    assign sd       = fwd_sel ? W_WD : m_rt_q;

    // Sweep FSM and EX/MEM register next-state.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        m_i_d     = m_i_q;
        m_pc_d    = m_pc_q;
        m_ao_d    = m_ao_q;
        m_rt_d    = m_rt_q;
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (en) begin
                    m_i_d  = E_I;
                    m_pc_d = E_PC;
                    m_ao_d = E_AO;
                    m_rt_d = E_RT;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            m_i_q     <= '0;
            m_pc_q    <= '0;
            m_ao_q    <= '0;
            m_rt_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            m_i_q     <= m_i_d;
            m_pc_q    <= m_pc_d;
            m_ao_q    <= m_ao_d;
            m_rt_q    <= m_rt_d;
        end
    end

    // Single write port: the sweep owns it while busy, stores afterwards.
    // Narrow store data is replicated across lanes so the byte enables
    // alone pick the destination.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = sd;
        wr_idx  = m_ao_q[AW+1:2];
        if (busy) begin
            wr_be   = 4'b1111;
            wr_data = '0;
            wr_idx  = clr_cnt_q;
        end else if (in_range) begin
            case (op)
                OP_SW: wr_be = 4'b1111;
                OP_SH: begin
                    wr_be   = m_ao_q[1] ? 4'b1100 : 4'b0011;
                    wr_data = {2{sd[15:0]}};
                end
                OP_SB: begin
                    wr_be   = 4'b0001 << m_ao_q[1:0];
                    wr_data = {4{sd[7:0]}};
                end
                default: wr_be = 4'b0000;
            endcase
        end
    end

    // Memory is not reset; the sweep clears it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    assign rd_word = in_range ? mem_q[m_ao_q[AW+1:2]] : '0;

    load_ext u_load_ext (
        .word    (rd_word),
        .addr_lo (m_ao_q[1:0]),
        .op      (op),
        .result  (M_RD)
    );

    assign M_I  = m_i_q;
    assign M_PC = m_pc_q;
    assign M_AO = m_ao_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mips_pkg::*;

    localparam int DW = 16;
    localparam int NB = 4 * DW;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [31:0] E_I = '0, E_PC = '0, E_AO = '0, E_RT = '0;
    logic        fwd_sel = 1'b0;
    logic [31:0] W_WD = '0;
    logic [31:0] M_I, M_PC, M_AO, M_RD;
    logic        busy;

    mem_stage #(.DM_WORDS(DW)) dut (
        .clk(clk), .reset(reset), .en(en),
        .E_I(E_I), .E_PC(E_PC), .E_AO(E_AO), .E_RT(E_RT),
        .fwd_sel(fwd_sel), .W_WD(W_WD),
        .M_I(M_I), .M_PC(M_PC), .M_AO(M_AO), .M_RD(M_RD), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: byte-addressed memory plus the M-stage contents.
    logic [7:0]  mb [NB];
    logic [31:0] ri, rpc, rao, rrt;
    int          sweep_left;
    logic [31:0] pc = 32'h0040_0000;

    function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] a);
        int base;
        int h;
        logic [15:0] hv;
        logic [7:0]  bv;
        if (a >= 32'(NB)) return 32'h0;
        base = int'(a) & ~3;
        h    = base + (a[1] ? 2 : 0);
        hv   = {mb[h+1], mb[h]};
        bv   = mb[int'(a)];
        case (op)
            OP_LW:   return {mb[base+3], mb[base+2], mb[base+1], mb[base]};
            OP_LH:   return {{16{hv[15]}}, hv};
            OP_LHU:  return {16'h0, hv};
            OP_LB:   return {{24{bv[7]}}, bv};
            OP_LBU:  return {24'h0, bv};
            default: return 32'h0;
        endcase
    endfunction

    task automatic ref_store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        int base;
        int h;
        if (a >= 32'(NB)) return;
        base = int'(a) & ~3;
        h    = base + (a[1] ? 2 : 0);
        case (op)
            OP_SW: for (int k = 0; k < 4; k++) mb[base+k] = d[8*k +: 8];
            OP_SH: begin mb[h] = d[7:0]; mb[h+1] = d[15:8]; end
            OP_SB: mb[int'(a)] = d[7:0];
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs as they stand,
    // then let the DUT take the same edge and settle.
    task automatic tick();
        if (reset) begin
            if (sweep_left > 0) begin
                sweep_left--;
                if (sweep_left == 0) for (int k = 0; k < NB; k++) mb[k] = 8'h00;
            end else begin
                ref_store(ri[31:26], rao, fwd_sel ? W_WD : rrt);
                if (en) begin ri = E_I; rpc = E_PC; rao = E_AO; rrt = E_RT; end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"}, 32'(busy), 32'(sweep_left > 0 || !reset));
        chk({tag, ".M_I"},  M_I,  ri);
        chk({tag, ".M_PC"}, M_PC, rpc);
        chk({tag, ".M_AO"}, M_AO, rao);
        chk({tag, ".M_RD"}, M_RD, ref_load(ri[31:26], rao));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sweep_left = DW;
        ri = '0; rpc = '0; rao = '0; rrt = '0;
        #1;
        chk("rst.busy", 32'(busy), 32'd1);
        chk("rst.M_I",  M_I,  32'h0);
        chk("rst.M_AO", M_AO, 32'h0);
        chk("rst.M_RD", M_RD, 32'h0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic count_sweep(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(DW));
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        E_I  = {op, 26'($urandom)};
        E_PC = pc;
        pc   = pc + 32'd4;
        E_AO = a;
        E_RT = d;
        en   = 1'b1;
        tick();
        check_all("issue");
    endtask

    logic [5:0]  ops [9];
    logic [31:0] li, lpc;

    initial begin
        ops[0] = OP_LW; ops[1] = OP_LB; ops[2] = OP_LBU; ops[3] = OP_LH; ops[4] = OP_LHU;
        ops[5] = OP_SW; ops[6] = OP_SB; ops[7] = OP_SH;  ops[8] = 6'b001000;

        // Sweep length and cleared contents.
        @(posedge clk); #1;
        do_reset();
        count_sweep("sweep_len");
        chk("sweep_busy_low", 32'(busy), 32'd0);
        for (int w = 0; w < DW; w++) begin
            issue(OP_LW, 32'(4 * w), 32'h0);
            chk("sweep_zero", M_RD, 32'h0);
        end

        // Reset in the middle of the sweep restarts it.
        en = 1'b0;
        do_reset();
        repeat (5) tick();
        do_reset();
        count_sweep("sweep_restart_len");

        // Word store then narrower loads.
        issue(OP_SW, 32'h4, 32'h1234_5678);
        issue(OP_LW, 32'h4, 32'h0);  chk("lw4",  M_RD, 32'h1234_5678);
        issue(OP_LB, 32'h7, 32'h0);  chk("lb7",  M_RD, 32'h0000_0012);
        issue(OP_LBU, 32'h5, 32'h0); chk("lbu5", M_RD, 32'h0000_0056);
        issue(OP_LH, 32'h6, 32'h0);  chk("lh6",  M_RD, 32'h0000_1234);

        // Byte store, sign extension.
        issue(OP_SB, 32'h6, 32'h0000_0080);
        issue(OP_LB, 32'h6, 32'h0);  chk("lb6",   M_RD, 32'hFFFF_FF80);
        issue(OP_LBU, 32'h6, 32'h0); chk("lbu6",  M_RD, 32'h0000_0080);
        issue(OP_LW, 32'h4, 32'h0);  chk("lw4sb", M_RD, 32'h1280_5678);

        // Halfword store to upper half of a cleared word.
        issue(OP_SH, 32'h2, 32'h0000_BEEF);
        issue(OP_LW, 32'h0, 32'h0);  chk("lw0",  M_RD, 32'hBEEF_0000);
        issue(OP_LH, 32'h2, 32'h0);  chk("lh2",  M_RD, 32'hFFFF_BEEF);
        issue(OP_LHU, 32'h3, 32'h0); chk("lhu3", M_RD, 32'h0000_BEEF);

        // Store-data forwarding from write-back.
        issue(OP_SW, 32'h8, 32'h0000_0001);
        fwd_sel = 1'b1;
        W_WD    = 32'hCAFE_BABE;
        issue(OP_LW, 32'h8, 32'h0);
        fwd_sel = 1'b0;
        chk("fwd_lw", M_RD, 32'hCAFE_BABE);

        // Stall holds the register.
        li  = E_I;
        lpc = E_PC;
        en  = 1'b0;
        E_I = 32'hDEAD_BEEF; E_PC = 32'h1111_1111; E_AO = 32'h2C; E_RT = 32'h5;
        repeat (3) tick();
        chk("stall.M_I",  M_I,  li);
        chk("stall.M_PC", M_PC, lpc);
        chk("stall.M_AO", M_AO, 32'h8);
        chk("stall.M_RD", M_RD, 32'hCAFE_BABE);

        // Out-of-range store is dropped; out-of-range load reads 0.
        issue(OP_SW, 32'(NB), 32'hFFFF_FFFF);
        issue(OP_LW, 32'(NB), 32'h0);
        chk("oor_lw", M_RD, 32'h0);
        for (int w = 0; w < DW; w++) issue(OP_LW, 32'(4 * w), 32'h0);
        chk("oor_w0", ref_load(OP_LW, 32'h0), 32'hBEEF_0000);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            E_I     = {ops[$urandom_range(0, 8)], 26'($urandom)};
            E_PC    = $urandom;
            E_AO    = 32'($urandom_range(0, NB + 7));
            E_RT    = $urandom;
            en      = ($urandom_range(0, 3) != 0);
            fwd_sel = $urandom_range(0, 1) == 1;
            W_WD    = $urandom;
            tick();
            check_all("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
